mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter sharing one single-port synchronous word RAM between the core's instruction-fetch port and its load/store port. It sits between the CPU core and the memory macro, so instruction and data memory can live in one array. Grants are issued per cycle with data-side priority and a starvation guard for fetch. Read responses are routed back to the requester that issued them, one cycle later.

## Interface
- ADDR_W, 10, word-address width (matches core IMEM/DMEM address ports)
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive lost arbitrations after which fetch wins; legal range 1..15
- CLK  in  1  clock, all state on rising edge
- RSTn  in  1  reset; one clock; reset is asynchronous and active-low
- if_req  in  1  fetch read request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data valid
- d_rdata  out  DATA_W  data read data
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after a read access

## Operation
- State: starve_cnt (4 bits), resp_owner (2 bits: NONE, IF, D).
- Arbitration (combinational, same cycle as request): force_if = (starve_cnt >= STARVE_LIMIT).
  - only d_req: d_gnt=1. only if_req: if_gnt=1. neither: no grant.
  - both: force_if=1 -> if_gnt=1; else d_gnt=1.
  - never both grants in one cycle; grants are 0 while RSTn=0.
- RAM drive: mem_en = if_gnt | d_gnt; mem_we = d_gnt & d_we; mem_addr/mem_wdata from the granted port; when idle mem_addr=0, mem_wdata=0, mem_we=0.
- starve_cnt at clock edge: cleared if if_gnt or !if_req; incremented (saturating at 15) if if_req & d_gnt; else held.
- resp_owner at clock edge: IF if if_gnt; D if d_gnt & !d_we; else NONE.
- Response: if_rvalid = (resp_owner==IF); d_rvalid = (resp_owner==D); each rdata = mem_rdata while its rvalid=1, else 0.
- Writes produce no rvalid; d_gnt is the write completion.

## Timing
- Reset values: starve_cnt=0, resp_owner=NONE; hence if_rvalid=d_rvalid=0, if_rdata=d_rdata=0, all grants and mem_* = 0.
- Grant latency 0 cycles (same cycle as req when won); read latency 1 cycle after grant.
- Fully pipelined: one grant per cycle, back-to-back grants to same or alternating ports; response of grant N overlaps grant N+1.
- Write at cycle N followed by read of same address at N+1 returns the new data at N+2 (RAM write-first not required).
- Fetch worst-case wait with continuous d_req: STARVE_LIMIT cycles lost, granted on cycle STARVE_LIMIT+1.
- Requester dropping req before gnt: request discarded, no side effect; starve_cnt clears if if_req drops.
- Reset asserted mid-read: resp_owner cleared asynchronously; the pending rvalid never appears; after release first grant allowed in the first cycle with RSTn=1.

## Test plan
- Reset: RSTn=0 with if_req=d_req=1 -> all grants, rvalids, rdata, mem_en = 0; after release starve_cnt=0.
- Fetch only: if_req, if_addr=0x004, RAM word 0x00500093 -> if_gnt same cycle, mem_addr=0x004, if_rvalid=1 and if_rdata=0x00500093 next cycle, d_rvalid=0.
- Contention: if_req=d_req=1 (d_we=0, d_addr=0x010) one cycle -> d_gnt=1, if_gnt=0; next cycle d_rvalid=1 and if_gnt=1.
- Starvation, STARVE_LIMIT=4: d_req held high for 8 cycles, if_req high -> d_gnt cycles 1-4, if_gnt cycle 5, d_gnt cycles 6-8 resumed.
- Write/readback: d write 0xDEADBEEF to 0x020, then d read 0x020 next cycle -> no rvalid for write, d_rdata=0xDEADBEEF two cycles after write grant.
- Reset mid-read: if_gnt at cycle N, RSTn low before edge N+1 -> if_rvalid stays 0, no stale data after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store.
// Data side wins ties unless fetch has lost STARVE_LIMIT arbitrations in a row.
module mem_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic [1:0] resp_owner_q, resp_owner_d;
  logic       force_if;

  assign force_if = (starve_cnt_q >= 4'(STARVE_LIMIT));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      starve_cnt_q <= 4'd0;
      resp_owner_q <= OWN_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  // Grants are gated by RSTn so nothing reaches the RAM while reset is held.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (RSTn) begin
      if (d_req && !(if_req && force_if)) d_gnt  = 1'b1;
      else if (if_req)                    if_gnt = 1'b1;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt || !if_req) begin
      starve_cnt_d = 4'd0;
    end else if (d_gnt && (starve_cnt_q != 4'hF)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    resp_owner_d = OWN_NONE;
    if (if_gnt)              resp_owner_d = OWN_IF;
    else if (d_gnt && !d_we) resp_owner_d = OWN_D;
  end

  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end

    // Read data is steered to whoever owned last cycle's read access.
    if_rvalid = (resp_owner_q == OWN_IF);
    d_rvalid  = (resp_owner_q == OWN_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid  ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural RAM behind the memory port.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        if_req, d_req, d_we;
  logic [9:0]  if_addr, d_addr;
  logic [31:0] d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;
  logic        preload;
  logic [31:0] ram [1024];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        if_req;
    logic [9:0]  if_addr;
    logic        d_req;
    logic        d_we;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic [5:0]  ctl;       // {if_gnt,d_gnt,if_rvalid,d_rvalid,mem_en,mem_we}
    logic [31:0] if_rdata;
    logic [31:0] d_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
  } vec_t;

  vec_t vecs [12];

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  logic [31:0] ram_rd;
  always @(posedge CLK) begin
    if (preload) begin
      ram[10'h004] <= 32'h00500093;
      ram[10'h008] <= 32'hAAAA5555;
      ram[10'h010] <= 32'h11112222;
      ram_rd       <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_rd <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_rd;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [9:0] ia, input logic dr, input logic dw,
                       input logic [9:0] da, input logic [31:0] dwd);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
  endtask

  task automatic next_cycle;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0, 6'b000000, 32'h0, 32'h0, 10'h000, 32'h0};
    vecs[1]  = '{1'b1, 10'h004, 1'b0, 1'b0, 10'h000, 32'h12345678, 6'b100010, 32'h0, 32'h0, 10'h004, 32'h0};
    vecs[2]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0, 6'b001000, 32'h00500093, 32'h0, 10'h000, 32'h0};
    vecs[3]  = '{1'b1, 10'h008, 1'b1, 1'b0, 10'h010, 32'h0, 6'b010010, 32'h0, 32'h0, 10'h010, 32'h0};
    vecs[4]  = '{1'b1, 10'h008, 1'b0, 1'b0, 10'h000, 32'h0, 6'b100110, 32'h0, 32'h11112222, 10'h008, 32'h0};
    vecs[5]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0, 6'b001000, 32'hAAAA5555, 32'h0, 10'h000, 32'h0};
    vecs[6]  = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h020, 32'hDEADBEEF, 6'b010011, 32'h0, 32'h0, 10'h020, 32'hDEADBEEF};
    vecs[7]  = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h020, 32'h0, 6'b010010, 32'h0, 32'h0, 10'h020, 32'h0};
    vecs[8]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0, 6'b000100, 32'h0, 32'hDEADBEEF, 10'h000, 32'h0};
    vecs[9]  = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h004, 32'h0, 6'b010010, 32'h0, 32'h0, 10'h004, 32'h0};
    vecs[10] = '{1'b1, 10'h010, 1'b0, 1'b0, 10'h000, 32'h0, 6'b100110, 32'h0, 32'h00500093, 10'h010, 32'h0};
    vecs[11] = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0, 6'b001000, 32'h11112222, 32'h0, 10'h000, 32'h0};

    // Reset held with both requesters active.
    RSTn = 1'b0;
    preload = 1'b1;
    drive(1'b1, 10'h004, 1'b1, 1'b0, 10'h010, 32'h0);
    next_cycle();
    next_cycle();
    preload = 1'b0;
    @(negedge CLK);
    check("reset_ctl", 128'({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we}), 128'(6'b0));
    check("reset_data", {if_rdata, d_rdata, mem_wdata, 22'h0, mem_addr}, 128'h0);
    next_cycle();
    RSTn = 1'b1;
    @(negedge CLK);
    check("first_after_reset", 128'({if_gnt, d_gnt}), 128'(2'b01));
    next_cycle();
    drive(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0);
    @(negedge CLK);
    check("first_read_resp", {96'h0, d_rvalid, if_rvalid, 30'h0} | 128'(d_rdata),
          {96'h0, 2'b10, 30'h0} | 128'(32'h11112222));
    next_cycle();

    // Table of single-cycle vectors.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].d_req, vecs[i].d_we,
            vecs[i].d_addr, vecs[i].d_wdata);
      @(negedge CLK);
      check($sformatf("vec%0d", i),
            {6'h0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we,
             if_rdata, d_rdata, mem_addr, mem_wdata},
            {6'h0, vecs[i].ctl, vecs[i].if_rdata, vecs[i].d_rdata,
             vecs[i].mem_addr, vecs[i].mem_wdata});
      next_cycle();
    end

    // Continuous data traffic: fetch forced through on the fifth contended cycle.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 10'h008, 1'b1, 1'b0, 10'h010, 32'h0);
      @(negedge CLK);
      check($sformatf("starve%0d", i), 128'({if_gnt, d_gnt}), 128'((i == 4) ? 2'b10 : 2'b01));
      next_cycle();
    end
    drive(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0);
    next_cycle();

    // Dropping if_req restarts the starvation count.
    for (int i = 0; i < 9; i++) begin
      drive((i != 3), 10'h008, 1'b1, 1'b0, 10'h010, 32'h0);
      @(negedge CLK);
      check($sformatf("starve_clr%0d", i), 128'({if_gnt, d_gnt}), 128'((i == 8) ? 2'b10 : 2'b01));
      next_cycle();
    end
    drive(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0);
    next_cycle();
    next_cycle();

    // Reset lands between a fetch grant and its response.
    drive(1'b1, 10'h004, 1'b0, 1'b0, 10'h000, 32'h0);
    @(negedge CLK);
    check("midrst_gnt", 128'(if_gnt), 128'(1'b1));
    #2;
    RSTn = 1'b0;
    next_cycle();
    check("midrst_norvalid", 128'({if_gnt, if_rvalid, mem_en}), 128'(3'b000));
    check("midrst_nordata", 128'(if_rdata), 128'(0));
    RSTn = 1'b1;
    @(negedge CLK);
    check("postrst_gnt", 128'({if_gnt, if_rvalid, d_rvalid}), 128'(3'b100));
    check("postrst_nostale", 128'(if_rdata), 128'(0));
    next_cycle();
    drive(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0);
    @(negedge CLK);
    check("postrst_resp", 128'({if_rvalid, if_rdata}), 128'({1'b1, 32'h00500093}));
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
